core_pio_out_pulse: RTL and testbench

Parametrised Avalon-MM output PIO slave with atomic bit set/clear registers and a shared auto-clearing pulse generator. It drives a DATA_WIDTH-bit `out_port` for LEDs, strobes and enables. It sits on the system interconnect as a zero-wait-state, read-latency-0 slave. It replaces the fixed 8-bit write-only-data output port in new designs.

---
 rtl/core_pio_out_pulse_if.sv | 25 ++
 rtl/core_pio_out_pulse.sv | 134 +++++++++++++
 tb/tb_core_pio_out_pulse.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/core_pio_out_pulse_if.sv
// Avalon-MM slave bus bundle for core_pio_out_pulse: word address, chip select,
// active-low write strobe, write data and combinational read data.
interface core_pio_out_pulse_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/core_pio_out_pulse.sv
// Output PIO with atomic set/clear registers and a shared auto-clearing pulse generator.
// Define CORE_PIO_PULSE_EN to build the PULSE_LEN/PULSE/STATUS registers, counter and pulse FSM.
module core_pio_out_pulse #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned           PULSE_W     = 16,
    parameter logic [PULSE_W-1:0]    PULSE_RESET = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    core_pio_out_pulse_if.slave   bus,
    output logic [DATA_WIDTH-1:0] out_port
);
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    logic                  wr;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  unused_wd;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^bus.writedata;
    assign out_port  = data_q;

`ifdef CORE_PIO_PULSE_EN
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
    localparam logic [2:0] ADDR_PULSE     = 3'd6;
    localparam logic [2:0] ADDR_STATUS    = 3'd7;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [PULSE_W-1:0]    cnt_q, cnt_d;
    logic [PULSE_W-1:0]    len_q, len_d;

    // Expiry is computed first so that later bus writes on the same edge override it.
    always_comb begin
        data_d  = data_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        state_d = state_q;
        if (state_q == ACTIVE) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - PULSE_W'(1);
            end else begin
                data_d  = data_q & ~mask_q;
                mask_d  = '0;
                state_d = IDLE;
            end
        end
        if (wr) begin
            case (bus.address)
                ADDR_DATA: begin
                    data_d  = wd;
                    mask_d  = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                ADDR_PULSE_LEN: len_d  = bus.writedata[PULSE_W-1:0];
                ADDR_OUTSET:    data_d = data_d | wd;
                ADDR_OUTCLEAR:  data_d = data_d & ~wd;
                ADDR_PULSE: begin
                    // Retrigger starts from the un-expired value: no clear on this edge.
                    if (wd != '0) begin
                        data_d  = data_q | wd;
                        mask_d  = mask_q | wd;
                        cnt_d   = len_q;
                        state_d = ACTIVE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:      bus.readdata = 32'(data_q);
            ADDR_PULSE_LEN: bus.readdata = 32'(len_q);
            ADDR_STATUS:    bus.readdata = 32'({mask_q, 7'b0, (state_q == ACTIVE)});
            default:        bus.readdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= RESET_VALUE;
            mask_q  <= '0;
            cnt_q   <= '0;
            len_q   <= PULSE_RESET;
            state_q <= IDLE;
        end else begin
            data_q  <= data_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            state_q <= state_d;
        end
    end
`else
    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (bus.address)
                ADDR_DATA:     data_d = wd;
                ADDR_OUTSET:   data_d = data_q | wd;
                ADDR_OUTCLEAR: data_d = data_q & ~wd;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.readdata = '0;
        if (bus.address == ADDR_DATA) begin
            bus.readdata = 32'(data_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end
`endif
endmodule

// File: tb/tb_core_pio_out_pulse.sv
// Directed self-checking bench for core_pio_out_pulse (DATA_WIDTH=8, RESET_VALUE=A5);
// exercises the pulse generator when CORE_PIO_PULSE_EN is defined, the plain PIO otherwise.
module tb_core_pio_out_pulse;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  out_port;
    logic [31:0] rv;
    int          checks = 0;
    int          errors = 0;

    core_pio_out_pulse_if bus_if();

    core_pio_out_pulse #(
        .DATA_WIDTH  (8),
        .RESET_VALUE (8'hA5),
        .PULSE_W     (16),
        .PULSE_RESET (16'h0000)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // Called at a negedge; the write lands on the next posedge, returns at the following negedge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus_if.address    = a;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.writedata  = d;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus_if.address    = a;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        #1;
        d = bus_if.readdata;
        bus_if.chipselect = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n           = 1'b0;
        bus_if.address    = 3'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 32'h0;
        #12;
        check("reset out_port", 32'(out_port), 32'h000000A5);
        bus_read(3'd0, rv); check("reset rd0", rv, 32'h000000A5);
        bus_read(3'd1, rv); check("reset rd1", rv, 32'h0);
        bus_read(3'd7, rv); check("reset rd7", rv, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);
        check("held after reset", 32'(out_port), 32'h000000A5);

        bus_write(3'd0, 32'h0000_000F);
        check("DATA out", 32'(out_port), 32'h0F);
        bus_read(3'd0, rv); check("DATA rd0", rv, 32'h0F);
        bus_write(3'd4, 32'hFFFF_FF30);
        check("OUTSET out", 32'(out_port), 32'h3F);
        bus_read(3'd0, rv); check("OUTSET rd0", rv, 32'h3F);
        bus_write(3'd5, 32'h0000_0005);
        check("OUTCLEAR out", 32'(out_port), 32'h3A);
        bus_read(3'd0, rv); check("OUTCLEAR rd0", rv, 32'h3A);
        bus_read(3'd4, rv); check("rd4 zero", rv, 32'h0);
        bus_read(3'd5, rv); check("rd5 zero", rv, 32'h0);
        bus_write(3'd2, 32'h0000_00FF);
        check("reserved wr out", 32'(out_port), 32'h3A);
        bus_read(3'd2, rv); check("rd2 zero", rv, 32'h0);
        bus_write(3'd3, 32'h0000_0000);
        check("reserved3 wr out", 32'(out_port), 32'h3A);

`ifdef CORE_PIO_PULSE_EN
        // Basic pulse: LEN=3 keeps bit 7 high for 4 cycles
        bus_write(3'd0, 32'h01);
        bus_write(3'd1, 32'h3);
        bus_read(3'd1, rv); check("PULSE_LEN rd", rv, 32'h3);
        bus_write(3'd6, 32'h80);
        check("pulse cyc0", 32'(out_port), 32'h81);
        bus_read(3'd7, rv); check("status active", rv, 32'h8001);
        for (int i = 1; i <= 3; i++) begin
            idle(1);
            check($sformatf("pulse cyc%0d", i), 32'(out_port), 32'h81);
        end
        idle(1);
        check("pulse expired", 32'(out_port), 32'h01);
        bus_read(3'd7, rv); check("status idle", rv, 32'h0);
        bus_write(3'd6, 32'h0);
        bus_read(3'd7, rv); check("zero pulse status", rv, 32'h0);
        check("zero pulse out", 32'(out_port), 32'h01);

        // Retrigger: both bits fall 6 cycles after the second write
        bus_write(3'd0, 32'h0);
        bus_write(3'd1, 32'h5);
        bus_write(3'd6, 32'h01);
        check("retrig first", 32'(out_port), 32'h01);
        idle(2);
        bus_write(3'd6, 32'h02);
        check("retrig second", 32'(out_port), 32'h03);
        for (int k = 1; k <= 5; k++) begin
            idle(1);
            check($sformatf("retrig hold%0d", k), 32'(out_port), 32'h03);
        end
        idle(1);
        check("retrig expired", 32'(out_port), 32'h00);

        // OUTSET on the expiry edge
        bus_write(3'd1, 32'h2);
        bus_write(3'd6, 32'h01);
        idle(2);
        bus_write(3'd4, 32'h01);
        check("outset@expiry out", 32'(out_port), 32'h01);
        bus_read(3'd7, rv); check("outset@expiry status", rv, 32'h0);

        // PULSE on the expiry edge reloads instead of clearing
        bus_write(3'd0, 32'h0);
        bus_write(3'd6, 32'h01);
        idle(2);
        bus_write(3'd6, 32'h02);
        check("pulse@expiry out", 32'(out_port), 32'h03);
        bus_read(3'd7, rv); check("pulse@expiry status", rv, 32'h0301);
        idle(3);
        check("pulse@expiry later", 32'(out_port), 32'h00);

        // DATA write cancels an active pulse
        bus_write(3'd1, 32'h4);
        bus_write(3'd6, 32'h10);
        idle(1);
        bus_write(3'd0, 32'h42);
        check("data cancel out", 32'(out_port), 32'h42);
        bus_read(3'd7, rv); check("data cancel status", rv, 32'h0);
        idle(6);
        check("data cancel held", 32'(out_port), 32'h42);

        // Asynchronous reset mid-pulse
        bus_write(3'd6, 32'h0F);
        check("pre-reset pulse", 32'(out_port), 32'h4F);
        #2 reset_n = 1'b0;
        #1;
        check("async reset out", 32'(out_port), 32'hA5);
        bus_read(3'd7, rv); check("async reset status", rv, 32'h0);
        bus_read(3'd1, rv); check("async reset len", rv, 32'h0);
`else
        bus_write(3'd6, 32'hFF);
        check("no-pulse out", 32'(out_port), 32'h3A);
        bus_write(3'd1, 32'h7);
        bus_read(3'd1, rv); check("no-pulse rd1", rv, 32'h0);
        bus_read(3'd7, rv); check("no-pulse rd7", rv, 32'h0);
        bus_write(3'd7, 32'hFF);
        check("no-pulse wr7 out", 32'(out_port), 32'h3A);
        #2 reset_n = 1'b0;
        #1;
        check("async reset out", 32'(out_port), 32'hA5);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        check("post-reset out", 32'(out_port), 32'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
